// File: rtl/remote_comm_if.sv
// Host-side command/response bundle for remote_comm: command request, serial lines and
// response status. The master drives commands and the RX line; the slave is remote_comm.
interface remote_comm_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        busy;
  logic        cmd_snt;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;
  logic        frm_err;

  modport master (
    output cmd, snd_cmd, clr_resp_rdy, RX,
    input  busy, cmd_snt, TX, resp, resp_rdy, frm_err
  );

  modport slave (
    input  cmd, snd_cmd, clr_resp_rdy, RX,
    output busy, cmd_snt, TX, resp, resp_rdy, frm_err
  );
endinterface

// File: rtl/remote_comm.sv
// Remote command source: sends a 16-bit command as two back-to-back 8N1 bytes (high byte
// first) on TX and independently receives 8N1 response bytes on RX.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 434
) (
  input logic          clk,
  input logic          rst,
  remote_comm_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BaudMax = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfMax = CntW'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TxIdle, TxHi, TxLo} tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [15:0]     shadow_q, shadow_d;
  logic            tx_q, tx_d;
  logic            cmd_snt;
  logic            accept;
  logic [7:0]      tx_byte;
  logic [2:0]      tx_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      shadow_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    shadow_d   = shadow_q;
    cmd_snt    = 1'b0;
    accept     = 1'b0;

    unique case (tx_state_q)
      TxIdle: begin
        if (bus.snd_cmd) begin
          accept     = 1'b1;
          tx_state_d = TxHi;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          shadow_d   = bus.cmd;
        end
      end
      TxHi, TxLo: begin
        if (tx_baud_q == BaudMax) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (tx_state_q == TxHi) begin
              tx_state_d = TxLo;
            end else begin
              tx_state_d = TxIdle;
              cmd_snt    = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    // TX is registered from next-state values so each bit starts exactly on its boundary.
    tx_byte = (tx_state_d == TxHi) ? shadow_d[15:8] : shadow_d[7:0];
    tx_idx  = 3'(tx_bit_d - 4'd1);
    if (tx_state_d == TxIdle) begin
      tx_d = 1'b1;
    end else if (tx_bit_d == 4'd0) begin
      tx_d = 1'b0;
    end else if (tx_bit_d == 4'd9) begin
      tx_d = 1'b1;
    end else begin
      tx_d = tx_byte[tx_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_bad_q, rx_bad_d;
  logic [7:0]      resp_q, resp_d;
  logic            resp_rdy_q, resp_rdy_d;
  logic            rx_set;
  logic            frm_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_bad_q   <= 1'b0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_s1_q    <= bus.RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_bad_q   <= rx_bad_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_bad_d   = rx_bad_q;
    rx_set     = 1'b0;
    frm_err    = 1'b0;

    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
          rx_baud_d  = '0;
        end
      end
      RxStart: begin
        if (rx_baud_q == HalfMax) begin
          rx_baud_d = '0;
          if (rx_s2_q) begin
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxData;
            rx_bit_d   = '0;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_baud_q == BaudMax) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RxStop: begin
        // After a framing error, hold here until the line returns high.
        if (rx_bad_q) begin
          if (rx_s2_q) begin
            rx_bad_d   = 1'b0;
            rx_state_d = RxIdle;
          end
        end else if (rx_baud_q == BaudMax) begin
          rx_baud_d = '0;
          if (rx_s2_q) begin
            rx_set     = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            frm_err  = 1'b1;
            rx_bad_d = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase

    resp_d = rx_set ? rx_shift_q : resp_q;
    if (rx_set) begin
      resp_rdy_d = 1'b1;
    end else if (bus.clr_resp_rdy || accept) begin
      resp_rdy_d = 1'b0;
    end else begin
      resp_rdy_d = resp_rdy_q;
    end
  end

  assign bus.TX       = tx_q;
  assign bus.busy     = (tx_state_q != TxIdle);
  assign bus.cmd_snt  = cmd_snt;
  assign bus.resp     = resp_q;
  assign bus.resp_rdy = resp_rdy_q;
  assign bus.frm_err  = frm_err;

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: frame-level TX model checked every cycle, plus
// directed and randomized RX traffic checked at byte granularity.
module tb_remote_comm;
  localparam int unsigned BD    = 16;
  localparam int          FRAME = 20 * BD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  remote_comm_if bus ();

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int frm_seen = 0;

  // Frame model: which cycle a command was accepted and what it carried.
  bit          m_active = 1'b0;
  int          m_start  = 0;
  logic [15:0] m_cmd    = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    int k;
    k = c - m_start;
    return m_active && (k >= 1) && (k <= FRAME);
  endfunction

  function automatic logic m_tx(input int c);
    int         k;
    int         b;
    int         p;
    logic [7:0] byt;
    k = c - m_start;
    if (!m_busy(c)) return 1'b1;
    b   = (k - 1) / BD;
    p   = b % 10;
    byt = (b < 10) ? m_cmd[15:8] : m_cmd[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return byt[3'(p - 1)];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
    end else if (bus.snd_cmd && !m_busy(cyc)) begin
      m_active <= 1'b1;
      m_start  <= cyc;
      m_cmd    <= bus.cmd;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("tx", 16'(bus.TX), 16'(m_tx(cyc)));
      chk("busy", 16'(bus.busy), 16'(m_busy(cyc)));
      chk("cmd_snt", 16'(bus.cmd_snt), 16'(m_active && (cyc - m_start == FRAME)));
      if (bus.frm_err) frm_seen++;
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] v);
    bus.cmd     = v;
    bus.snd_cmd = 1'b1;
    @(negedge clk);
    bus.snd_cmd = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic stop);
    bus.RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = d[i];
      repeat (BD) @(negedge clk);
    end
    bus.RX = stop;
    repeat (BD) @(negedge clk);
    bus.RX = 1'b1;
    if (!stop) repeat (BD) @(negedge clk);
  endtask

  task automatic clr_pulse();
    bus.clr_resp_rdy = 1'b1;
    @(negedge clk);
    bus.clr_resp_rdy = 1'b0;
  endtask

  initial begin
    int         s;
    int         f0;
    bit         got;
    logic [15:0] v;
    logic [7:0]  d;

    bus.cmd          = '0;
    bus.snd_cmd      = 1'b0;
    bus.clr_resp_rdy = 1'b0;
    bus.RX           = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(bus.TX), 16'd1);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_cmd_snt", 16'(bus.cmd_snt), 16'd0);
    chk("rst_resp", 16'(bus.resp), 16'h00);
    chk("rst_resp_rdy", 16'(bus.resp_rdy), 16'd0);
    chk("rst_frm_err", 16'(bus.frm_err), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x2301 frame with a cmd change and an ignored request while busy.
    s = cyc;
    send_cmd(16'h2301);
    bus.cmd = 16'hBEEF;
    wait_to(s + 1);
    chk("t1_start", 16'(bus.TX), 16'd0);
    chk("t1_busy1", 16'(bus.busy), 16'd1);
    wait_to(s + 17);
    chk("t1_hi_d0", 16'(bus.TX), 16'd1);
    wait_to(s + 49);
    chk("t1_hi_d2", 16'(bus.TX), 16'd0);
    wait_to(s + 100);
    send_cmd(16'hFFFF);
    wait_to(s + 145);
    chk("t1_hi_stop", 16'(bus.TX), 16'd1);
    wait_to(s + 161);
    chk("t1_lo_start", 16'(bus.TX), 16'd0);
    wait_to(s + 177);
    chk("t1_lo_d0", 16'(bus.TX), 16'd1);
    wait_to(s + 193);
    chk("t1_lo_d1", 16'(bus.TX), 16'd0);
    wait_to(s + 320);
    chk("t1_cmd_snt", 16'(bus.cmd_snt), 16'd1);
    chk("t1_busy320", 16'(bus.busy), 16'd1);
    wait_to(s + 321);
    chk("t1_busy_drop", 16'(bus.busy), 16'd0);
    chk("t1_idle", 16'(bus.TX), 16'd1);
    repeat (4) @(negedge clk);

    // Valid responses and clear.
    rx_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_resp", 16'(bus.resp), 16'h00A5);
    chk("t3_rdy", 16'(bus.resp_rdy), 16'd1);
    clr_pulse();
    chk("t3_clr", 16'(bus.resp_rdy), 16'd0);
    rx_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_resp2", 16'(bus.resp), 16'h005A);
    chk("t3_rdy2", 16'(bus.resp_rdy), 16'd1);
    clr_pulse();

    // Framing error.
    f0 = frm_seen;
    rx_byte(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_frm_cnt", 16'(frm_seen), 16'(f0 + 1));
    chk("t4_rdy", 16'(bus.resp_rdy), 16'd0);
    chk("t4_resp", 16'(bus.resp), 16'h005A);

    // Short low glitch, then a good byte.
    f0 = frm_seen;
    bus.RX = 1'b0;
    repeat (4) @(negedge clk);
    bus.RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    chk("t5_glitch_rdy", 16'(bus.resp_rdy), 16'd0);
    chk("t5_glitch_frm", 16'(frm_seen), 16'(f0));
    rx_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_resp", 16'(bus.resp), 16'h005A);
    chk("t5_rdy", 16'(bus.resp_rdy), 16'd1);

    // Accept clears resp_rdy; reset mid high byte aborts the frame.
    s = cyc;
    send_cmd(16'h4321);
    wait_to(s + 2);
    chk("t6_accept_clr", 16'(bus.resp_rdy), 16'd0);
    wait_to(s + 60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_tx", 16'(bus.TX), 16'd1);
    chk("t6_rst_busy", 16'(bus.busy), 16'd0);
    repeat (5) @(negedge clk);
    s = cyc;
    send_cmd(16'h4321);
    wait_to(s + 320);
    chk("t6_cmd_snt", 16'(bus.cmd_snt), 16'd1);
    wait_to(s + 324);

    // Stop-bit sample coinciding with a held clear: the set must win.
    got = 1'b0;
    fork
      rx_byte(8'hA5, 1'b1);
      begin
        bus.clr_resp_rdy = 1'b1;
        for (int i = 0; i < 12 * BD; i++) begin
          @(negedge clk);
          if (bus.resp_rdy) begin
            got = 1'b1;
            break;
          end
        end
        bus.clr_resp_rdy = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("t7_set_wins", 16'(got), 16'd1);
    chk("t7_rdy", 16'(bus.resp_rdy), 16'd1);
    chk("t7_resp", 16'(bus.resp), 16'h00A5);
    clr_pulse();

    // Random commands with concurrent random responses.
    for (int n = 0; n < 4; n++) begin
      v = 16'($urandom);
      d = 8'($urandom_range(0, 255));
      s = cyc;
      fork
        send_cmd(v);
        rx_byte(d, 1'b1);
      join
      wait_to(s + FRAME + 3);
      chk("rnd_resp", 16'(bus.resp), 16'(d));
      chk("rnd_rdy", 16'(bus.resp_rdy), 16'd1);
      clr_pulse();
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
